// File: rtl/sat_round_pipe.sv
// sat_round_pipe: two-stage round-half-up shift (stage 1) and saturation (stage 2)
// for complex samples, with valid/ready handshake on both sides.
//   clk, rstn              clock, async active-low reset
//   in_valid/in_ready      input handshake; in_re/in_im (IW, signed), shift (SW)
//   out_valid/out_ready    output handshake; out_re/out_im (OW, signed), out_sat {im, re}
//   clr_cnt, sat_cnt       clear / count of saturated output beats
// Optional macro SAT_RND_CNT_EN enables the saturation counter; otherwise sat_cnt = 0.
module sat_round_pipe #(
  parameter int IW = 17,
  parameter int OW = 16,
  parameter int SW = 4,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_re,
  input  logic signed [IW-1:0] in_im,
  input  logic [SW-1:0]        shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic [1:0]           out_sat,
  input  logic                 clr_cnt,
  output logic [CW-1:0]        sat_cnt
);

  localparam int SHW = $clog2(IW);

  logic [SHW-1:0]       sh;
  logic                 s1_valid_q, s1_valid_d;
  logic signed [IW:0]   s1_re_q, s1_re_d;
  logic signed [IW:0]   s1_im_q, s1_im_d;
  logic                 s2_valid_q, s2_valid_d;
  logic signed [OW-1:0] out_re_q, out_re_d;
  logic signed [OW-1:0] out_im_q, out_im_d;
  logic [1:0]           out_sat_q, out_sat_d;
  logic                 s1_load, s2_load;
  logic [OW:0]          sat_re, sat_im;

  function automatic logic signed [IW:0] rnd(input logic signed [IW-1:0] x,
                                             input logic [SHW-1:0] s);
    logic signed [IW:0] xe;
    logic signed [IW:0] half;
    xe = {x[IW-1], x};
    if (s == '0) return xe;
    half = (IW+1)'(1) << (s - SHW'(1));
    return (xe + half) >>> s;
  endfunction

  // Returns {clamped, value}; fits when all bits from the OW-1 sign bit upward agree.
  function automatic logic [OW:0] sat(input logic signed [IW:0] v);
    logic fits;
    fits = (&v[IW:OW-1]) | ~(|v[IW:OW-1]);
    if (fits)       return {1'b0, v[OW-1:0]};
    else if (v[IW]) return {1'b1, 1'b1, {(OW-1){1'b0}}};
    else            return {1'b1, 1'b0, {(OW-1){1'b1}}};
  endfunction

  always_comb begin
    if (32'(shift) > 32'(IW - 1)) sh = SHW'(IW - 1);
    else                          sh = SHW'(shift);
  end

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  assign sat_re = sat(s1_re_q);
  assign sat_im = sat(s1_im_q);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_re_d = rnd(in_re, sh);
        s1_im_d = rnd(in_im, sh);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    out_sat_d  = out_sat_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_re_d  = sat_re[OW-1:0];
        out_im_d  = sat_im[OW-1:0];
        out_sat_d = {sat_im[OW], sat_re[OW]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s2_valid_q <= 1'b0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      out_sat_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s2_valid_q <= s2_valid_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_sat   = out_sat_q;

`ifdef SAT_RND_CNT_EN
  logic [CW-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_cnt)
      sat_cnt_d = '0;
    else if (s2_valid_q && out_ready && (|out_sat_q) && (sat_cnt_q != '1))
      sat_cnt_d = sat_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_sat_round_pipe.sv
module tb_sat_round_pipe;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [1:0]         sat;
  } exp_t;

  localparam int CNT_ON =
`ifdef SAT_RND_CNT_EN
    1;
`else
    0;
`endif

  logic               clk;
  logic               rstn;
  logic               in_valid, in_ready;
  logic signed [16:0] in_re, in_im;
  logic [3:0]         shift;
  logic               out_valid, out_ready;
  logic signed [15:0] out_re, out_im;
  logic [1:0]         out_sat;
  logic               clr_cnt;
  logic [1:0]         sat_cnt;

  logic               in_valid2, in_ready2;
  logic signed [16:0] in_re2, in_im2;
  logic [4:0]         shift2;
  logic               out_valid2, out_ready2;
  logic signed [15:0] out_re2, out_im2;
  logic [1:0]         out_sat2;
  logic               clr_cnt2;
  logic [1:0]         sat_cnt2;

  int   checks   = 0;
  int   failures = 0;
  int   tog_mode = 0;
  int   exp_cnt  = 0;
  exp_t sb[$];

  sat_round_pipe #(.IW(17), .OW(16), .SW(4), .CW(2)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_sat(out_sat),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  sat_round_pipe #(.IW(17), .OW(16), .SW(5), .CW(2)) u_dut5 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_re(in_re2), .in_im(in_im2), .shift(shift2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_re(out_re2), .out_im(out_im2), .out_sat(out_sat2),
    .clr_cnt(clr_cnt2), .sat_cnt(sat_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: round-half-up arithmetic shift then clamp to 16-bit signed.
  function automatic logic [16:0] model_comp(input longint x, input int shv);
    longint v;
    int     s;
    s = (shv > 16) ? 16 : shv;
    v = x;
    if (s > 0) v = (x + (longint'(1) << (s - 1))) >>> s;
    if (v > 32767)       return {1'b1, 16'sd32767};
    else if (v < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, 16'(v)};
  endfunction

  function automatic exp_t model(input logic signed [16:0] re, input logic signed [16:0] im,
                                 input logic [3:0] shv);
    logic [16:0] r, i;
    exp_t e;
    r = model_comp(longint'(re), int'(shv));
    i = model_comp(longint'(im), int'(shv));
    e.re  = r[15:0];
    e.im  = i[15:0];
    e.sat = {i[16], r[16]};
    return e;
  endfunction

  // Scoreboard monitor: in_ready occupancy model, counter model, push on accept, pop on output.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_cnt = 0;
    end else begin
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      check("sat_cnt", sat_cnt, exp_cnt);
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_output got=%0d exp=none", out_re);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          check("out_sat", out_sat, e.sat);
`ifdef SAT_RND_CNT_EN
          if (!clr_cnt && e.sat != 2'b00 && exp_cnt < 3) exp_cnt++;
`endif
        end
      end
      if (clr_cnt) exp_cnt = 0;
      if (in_valid && in_ready) sb.push_back(model(in_re, in_im, shift));
    end
  end

  task automatic apply_ready();
    case (tog_mode)
      1:       out_ready = !out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic send(input int re, input int im, input int sh);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_re    = 17'(re);
    in_im    = 17'(im);
    shift    = 4'(sh);
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      apply_ready();
    end
    in_valid = 1'b0;
    check("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      apply_ready();
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; shift = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    in_valid2 = 1'b0; in_re2 = '0; in_im2 = '0; shift2 = '0;
    out_ready2 = 1'b1; clr_cnt2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 1'b1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Positive saturation, exact 2-cycle latency
    send(65535, 0, 0);
    check("lat_stage1_only", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_out_valid", out_valid, 1'b1);
    check("lat_out_re", out_re, 32767);
    check("lat_out_sat", out_sat, 2'b01);
    idle(2);

    // Rounding half-up both signs, negative saturation
    send(5, -5, 1);
    send(-65536, 0, 0);
    idle(4);

    // Counter holds at 3 after 5 saturating beats
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) send(65535, -65536, 0);
    idle(4);
    check("cnt_hold", sat_cnt, CNT_ON ? 3 : 0);

    // Clear wins over a saturating transfer in the same cycle
    send(65535, 0, 0);
    @(posedge clk);
    #1;
    check("clr_xfer_valid", out_valid, 1'b1);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check("clr_priority", sat_cnt, 0);
    idle(2);

    // 8-beat stream with out_ready toggling every cycle
    tog_mode  = 1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i * 9001 - 30000, -i * 7777 + 1, i);
    idle(12);
    tog_mode  = 0;
    out_ready = 1'b1;
    check("stream_drained", sb.size(), 0);

    // Random beats and shifts under random backpressure
    tog_mode = 2;
    for (int i = 0; i < 24; i++)
      send(int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
           int'($urandom_range(0, 15)));
    idle(12);
    tog_mode  = 0;
    out_ready = 1'b1;
    idle(2);

    // Largest unclamped shift on the SW=4 instance
    send(65535, -65536, 15);
    idle(4);

    // SW=5 instance: shift 20 clamps to 16
    @(posedge clk);
    #1;
    in_valid2 = 1'b1; in_re2 = 17'sd65535; in_im2 = -17'sd65536; shift2 = 5'd20;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    check("clamp_valid", out_valid2, 1'b1);
    check("clamp_re", out_re2, 1);
    check("clamp_im", out_im2, -1);
    check("clamp_sat", out_sat2, 0);
    idle(2);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(100, 200, 0);
    send(300, 400, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_re", out_re, 0);
    check("mid_rst_out_sat", out_sat, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    sb.delete();
    @(posedge clk);
    #3;
    rstn      = 1'b1;
    out_ready = 1'b1;
    idle(8);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_round_pipe.md
SAT_ROUND_PIPE -- requirements
Module: sat_round_pipe

Interface
REQ-001 SHALL have parameter IW, default 17: input component width (signed).
REQ-002 SHALL have parameter OW, default 16: output component width (signed); IW > OW required.
REQ-003 SHALL have parameter SW, default 4: width of shift control.
REQ-004 SHALL have parameter CW, default 16: saturation counter width.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 in_re, in_im  input  IW each  signed real/imag samples.
REQ-010 shift  input  SW  right-shift amount, sampled with the beat.
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 out_re, out_im  output  OW each  rounded, saturated results.
REQ-014 out_sat  output  2  per-beat saturation flags {im, re}.
REQ-015 clr_cnt  input  1  synchronous clear of sat_cnt.
REQ-016 sat_cnt  output  CW  count of saturated output beats.

Function
REQ-017 SHALL be a 2-stage pipeline: stage 1 rounds and shifts, stage 2 saturates; latency exactly 2 cycles when unstalled; throughput 1 beat/cycle.
REQ-018 Transfer occurs on valid && ready at each port; data and valid hold stable while out_valid && !out_ready.
REQ-019 Stage 2 loads when !s2_valid || out_ready; stage 1 loads when !s1_valid || stage-2-load; in_ready = !s1_valid || stage-2-load (combinational from out_ready).
REQ-020 Effective shift sh = min(shift, IW-1).
REQ-021 Rounding: round-half-up; for sh>0 compute (x + 2^(sh-1)) >>> sh in IW+1 bits (arithmetic); sh=0 passes x unchanged, sign-extended to IW+1.
REQ-022 Saturation: value > 2^(OW-1)-1 -> 2^(OW-1)-1; value < -2^(OW-1) -> -2^(OW-1); otherwise low OW bits.
REQ-023 out_sat[0]/[1] SHALL be 1 when re/im was clamped, aligned with the same beat.
REQ-024 Real and imaginary paths identical and independent.
REQ-025 sat_cnt increments by 1 per transferred output beat with |out_sat; holds at 2^CW-1 (no wrap).
REQ-026 clr_cnt has priority over increment in the same cycle; result 0.
REQ-027 No beat is dropped or duplicated under any out_ready pattern.

Reset
REQ-028 On rstn low: s1_valid, s2_valid, out_valid = 0; out_re, out_im, out_sat = 0; sat_cnt = 0; in_ready = 1 after reset release.
REQ-029 Reset mid-stream discards all in-flight beats; none emerge after release.

Configuration
REQ-030 Macro SAT_RND_CNT_EN: defined -> sat_cnt and clr_cnt logic as REQ-025/026; undefined -> sat_cnt tied 0, clr_cnt ignored, no counter registers.

Verification (IW=17, OW=16, CW=2 where noted)
REQ-031 in_re=65535, shift=0 -> out_re=32767, out_sat[0]=1, 2 cycles later.
REQ-032 in_re=5, in_im=-5, shift=1 -> out_re=3, out_im=-2, out_sat=0; in_re=-65536, shift=0 -> out_re=-32768, out_sat[0]=1.
REQ-033 Stream 8 beats, out_ready toggled 1/0 each cycle -> all 8 outputs in order, values unchanged, in_ready low only while both stages full and out_ready=0.
REQ-034 CW=2, 5 saturating beats transferred -> sat_cnt=3; clr_cnt with a saturating transfer same cycle -> sat_cnt=0.
REQ-035 rstn asserted with 2 beats in flight -> out_valid=0 immediately, no outputs after release, sat_cnt=0.
REQ-036 shift=15 (>IW-1 clamp untouched), shift=20 with SW=5 -> treated as 16; in_re=65535 -> out_re=1.
